exc_ctrl: RTL

//  Exception/interrupt sequencer for the 5-stage LEGv8 pipeline. Watches writeback for

---
 rtl/exc_pkg.sv | 17 +
 rtl/irq_sync.sv | 27 ++
 rtl/exc_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, ESR syndromes
// and the default exception vector.
package exc_pkg;

    typedef enum logic [1:0] {
        EXC_RUN     = 2'd0,
        EXC_HANDLER = 2'd1,
        EXC_HALT    = 2'd2
    } exc_state_t;

    localparam logic [31:0] ESR_NONE  = 32'd0;
    localparam logic [31:0] ESR_INVOP = 32'd1;
    localparam logic [31:0] ESR_IRQ   = 32'd2;

    localparam logic [63:0] VBAR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous interrupt level; 2-cycle latency,
// clears to 0 on reset.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], async_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/IRQ sequencer: RUN/HANDLER/HALT state, ERR_PC/ESR capture, fetch redirect and
// same-cycle flushes. EXC_IRQ_EN enables synchronized external interrupt entry.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          N    = 64,
    parameter logic [N-1:0] VBAR = N'(VBAR_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         retire_W,
    input  logic         invop_W,
    input  logic         eret_W,
    input  logic [N-1:0] PC_W,
    input  logic [N-1:0] NextPC_W,
    input  logic         ext_irq,
    output logic         EProc_F,
    output logic [N-1:0] EVAddr_F,
    output logic         Flush_D,
    output logic         Flush_E,
    output logic         Flush_M,
    output logic [N-1:0] ERR_PC,
    output logic [31:0]  ESR,
    output logic         in_handler,
    output logic         halt,
    output logic         irq_ack
);

    exc_state_t   state_q, state_d;
    logic [N-1:0] err_pc_q, err_pc_d;
    logic [31:0]  esr_q, esr_d;
    logic         irq_s;

`ifdef EXC_IRQ_EN
    irq_sync u_irq_sync (
        .clk     (clk),
        .rst     (reset),
        .async_i (ext_irq),
        .sync_o  (irq_s)
    );
`else
    logic unused_ext_irq;
    assign unused_ext_irq = ext_irq;
    assign irq_s          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        err_pc_d = err_pc_q;
        esr_d    = esr_q;
        EProc_F  = 1'b0;
        EVAddr_F = '0;
        irq_ack  = 1'b0;
        unique case (state_q)
            EXC_RUN: begin
                // A faulting instruction takes priority; the IRQ level stays pending.
                if (retire_W && invop_W) begin
                    EProc_F  = 1'b1;
                    EVAddr_F = VBAR;
                    err_pc_d = PC_W;
                    esr_d    = ESR_INVOP;
                    state_d  = EXC_HANDLER;
                end else if (retire_W && irq_s) begin
                    EProc_F  = 1'b1;
                    EVAddr_F = VBAR;
                    err_pc_d = NextPC_W;
                    esr_d    = ESR_IRQ;
                    irq_ack  = 1'b1;
                    state_d  = EXC_HANDLER;
                end
            end
            EXC_HANDLER: begin
                if (retire_W && invop_W) begin
                    state_d = EXC_HALT;
                end else if (retire_W && eret_W) begin
                    EProc_F  = 1'b1;
                    EVAddr_F = err_pc_q;
                    state_d  = EXC_RUN;
                end
            end
            EXC_HALT: begin
                state_d = EXC_HALT;
            end
            default: begin
                state_d = EXC_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EXC_RUN;
            err_pc_q <= '0;
            esr_q    <= ESR_NONE;
        end else begin
            state_q  <= state_d;
            err_pc_q <= err_pc_d;
            esr_q    <= esr_d;
        end
    end

    assign Flush_D    = EProc_F;
    assign Flush_E    = EProc_F;
    assign Flush_M    = EProc_F;
    assign ERR_PC     = err_pc_q;
    assign ESR        = esr_q;
    assign in_handler = (state_q == EXC_HANDLER);
    assign halt       = (state_q == EXC_HALT);

endmodule
